// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic bit params_ok(int w, int d);
        return (d >= 1) && (d <= w) && ((w % d) == 0);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit adder slice; cmsb is the carry into the top bit.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] full;

    assign full = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
    assign s    = full[DIGIT-1:0];
    assign cout = full[DIGIT];

    generate
        if (DIGIT == 1) begin : g_one
            assign cmsb = cin;
        end else begin : g_low
            // Sum of the lower bits only; its top bit is the MSB carry-in.
            logic [DIGIT-1:0] low;
            assign low  = {1'b0, x[DIGIT-2:0]} + {1'b0, y[DIGIT-2:0]}
                        + {{(DIGIT-1){1'b0}}, cin};
            assign cmsb = low[DIGIT-1];
        end
    endgenerate

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: one DIGIT-bit slice reused over WIDTH/DIGIT cycles.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
            $fatal(1, "digit_serial_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0] slice_s;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [WIDTH-1:0] s_ext;

    digit_adder #(
        .DIGIT(DIGIT)
    ) u_slice (
        .x   (a_q[DIGIT-1:0]),
        .y   (b_q[DIGIT-1:0]),
        .cin (carry_q),
        .s   (slice_s),
        .cout(slice_cout),
        .cmsb(slice_cmsb)
    );

    assign s_ext = WIDTH'(slice_s);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        co_d      = co_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = ci ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                // Result digits enter at the MSB so the LSB digit lands last at bit 0.
                sum_d   = (sum_q >> DIGIT) | (s_ext << (WIDTH - DIGIT));
                carry_d = slice_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
                    co_d    = slice_cout;
                    ovf_d   = slice_cmsb ^ slice_cout;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum = sum_q;
    assign co  = co_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench: directed vectors on DIGIT=4, random sweep on DIGIT=1 and 16.
module tb_digit_serial_adder;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mc, input logic ms);
        exp_t        e;
        logic [15:0] bb;
        logic [16:0] t;
        bb    = ms ? ~mb : mb;
        t     = {1'b0, ma} + {1'b0, bb} + {16'd0, mc ^ ms};
        e.s   = t[15:0];
        e.c   = t[16];
        e.v   = (ma[15] == bb[15]) && (t[15] != ma[15]);
        e.acc = 0;
        return e;
    endfunction

    logic        rstN, in_valid, in_ready, ci, sub;
    logic        out_valid, out_ready, co, ovf;
    logic [15:0] a, b, sum;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co), .ovf(ovf)
    );

    exp_t exp_q[$];
    logic ov_prev = 1'b0;
    int   first_cyc = 0;

    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !ov_prev) first_cyc = cyc;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("d4_unexpected_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("d4_sum", {16'd0, sum}, {16'd0, e.s});
                chk("d4_co", {31'd0, co}, {31'd0, e.c});
                chk("d4_ovf", {31'd0, ovf}, {31'd0, e.v});
                chk("d4_latency", first_cyc - e.acc, 32'd4);
            end
        end
        ov_prev = out_valid;
    end

    task automatic send(input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic ts,
                        input logic [15:0] es, input logic ec, input logic ev,
                        input bit push);
        exp_t e;
        int   k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) chk("d4_in_ready_timeout", 32'd0, 32'd1);
        a = ta; b = tb_; ci = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; ci = 1'b1; sub = 1'b1;
        e.s = es; e.c = ec; e.v = ev; e.acc = cyc;
        if (push) exp_q.push_back(e);
    endtask

    task automatic wait_empty();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            chk("d4_result_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    generate
        for (genvar g = 0; g < 2; g++) begin : sw
            localparam int D   = (g == 0) ? 1 : 16;
            localparam int LAT = 16 / D;
            logic        r, iv, ir, ov, orr, c_i, s_i, co_o, ovf_o;
            logic [15:0] a_i, b_i, s_o;
            exp_t        q[$];
            logic        prev = 1'b0;
            int          first = 0;
            bit          done = 1'b0;

            digit_serial_adder #(.WIDTH(16), .DIGIT(D)) u (
                .clk(clk), .rstN(r), .in_valid(iv), .in_ready(ir),
                .a(a_i), .b(b_i), .ci(c_i), .sub(s_i),
                .out_valid(ov), .out_ready(orr),
                .sum(s_o), .co(co_o), .ovf(ovf_o)
            );

            always @(negedge clk) begin
                exp_t e;
                if (ov && !prev) first = cyc;
                if (ov && orr) begin
                    if (q.size() == 0) begin
                        chk($sformatf("d%0d_unexpected_out", D), 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("d%0d_sum", D), {16'd0, s_o}, {16'd0, e.s});
                        chk($sformatf("d%0d_co", D), {31'd0, co_o}, {31'd0, e.c});
                        chk($sformatf("d%0d_ovf", D), {31'd0, ovf_o}, {31'd0, e.v});
                        chk($sformatf("d%0d_latency", D), first - e.acc, LAT);
                    end
                end
                prev = ov;
            end

            initial begin
                exp_t e;
                int   k;
                r = 1'b0; iv = 1'b0; orr = 1'b1;
                a_i = '0; b_i = '0; c_i = 1'b0; s_i = 1'b0;
                repeat (3) @(posedge clk);
                #1 r = 1'b1;
                for (int n = 0; n < 1000; n++) begin
                    k = 0;
                    while (!ir && k < 200) begin
                        orr = 1'($urandom_range(0, 1));
                        @(posedge clk); #1;
                        k++;
                    end
                    if (!ir) chk($sformatf("d%0d_in_ready_timeout", D), 32'd0, 32'd1);
                    a_i = 16'($urandom); b_i = 16'($urandom);
                    c_i = 1'($urandom); s_i = 1'($urandom);
                    e = model(a_i, b_i, c_i, s_i);
                    iv = 1'b1;
                    @(posedge clk); #1;
                    iv = 1'b0;
                    a_i = 16'($urandom); b_i = 16'($urandom);
                    e.acc = cyc;
                    q.push_back(e);
                    orr = 1'($urandom_range(0, 1));
                end
                orr = 1'b1;
                k = 0;
                while (q.size() != 0 && k < 200) begin
                    @(posedge clk); #1;
                    k++;
                end
                chk($sformatf("d%0d_drain", D), q.size(), 32'd0);
                done = 1'b1;
            end
        end
    endgenerate

    initial begin
        int k;
        int nov;
        rstN = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_co", {31'd0, co}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rstN = 1'b1;

        send(16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0, 1); wait_empty();
        send(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1); wait_empty();
        send(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 1); wait_empty();
        send(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0, 1); wait_empty();
        send(16'h0010, 16'h0003, 1, 1, 16'h000C, 1, 0, 1); wait_empty();
        send(16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0, 1); wait_empty();
        send(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 1); wait_empty();

        // Reset at the second RUN edge, right after a result with co=ovf=1.
        send(16'h1111, 16'h2222, 0, 0, 16'h0000, 0, 0, 0);
        @(posedge clk); #1 rstN = 1'b0;
        @(posedge clk); #1 rstN = 1'b1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum", {16'd0, sum}, 32'd0);
        chk("midrst_co", {31'd0, co}, 32'd0);
        chk("midrst_ovf", {31'd0, ovf}, 32'd0);
        nov = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) nov++;
        end
        chk("midrst_no_out_valid", nov, 32'd0);
        send(16'hABCD, 16'h1111, 0, 0, 16'hBCDE, 0, 0, 1); wait_empty();

        out_ready = 1'b0;
        send(16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0, 1);
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_sum", {16'd0, sum}, 32'h0100);
            chk("bp_hold_co", {31'd0, co}, 32'd0);
            chk("bp_hold_ovf", {31'd0, ovf}, 32'd0);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        wait_empty();
        send(16'h2000, 16'h3000, 0, 1, 16'hF000, 0, 0, 1); wait_empty();

        k = 0;
        while (!(sw[0].done && sw[1].done) && k < 60000) begin
            @(posedge clk);
            k++;
        end
        chk("sweep_done", {31'd0, sw[0].done && sw[1].done}, 32'd1);
        chk("d4_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
